// File: rtl/fp_seq_accumulator_pkg.sv
// Shared definitions for the sequential floating-point accumulator.
// Contents:
//   - default exponent and mantissa widths;
//   - the command code this block serves;
//   - the FSM state enum;
//   - width-independent classifiers that work on pre-decoded field
//     properties, so any ExpWidth/MantWidth pair can use them.
package fp_seq_accumulator_pkg;

  localparam int unsigned DefExpWidth  = 8;
  localparam int unsigned DefMantWidth = 7;

  localparam logic [7:0] CmdOpAccumulate = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_DONE
  } acc_state_e;

  // Only the all-zero pattern is Zero. A negative zero counts as NaN.
  function automatic logic is_zero(input logic sgn, input logic exp_zero,
                                   input logic mant_zero);
    return exp_zero & mant_zero & ~sgn;
  endfunction

  function automatic logic is_inf(input logic exp_ones, input logic mant_zero);
    return exp_ones & mant_zero;
  endfunction

  // Any exp==0 pattern other than Zero is NaN, because there are no
  // denormals. An all-ones exponent with a non-zero mantissa is also NaN.
  function automatic logic is_nan(input logic sgn, input logic exp_zero,
                                  input logic exp_ones, input logic mant_zero);
    return (exp_zero & ~(mant_zero & ~sgn)) | (exp_ones & ~mant_zero);
  endfunction

endpackage

// File: rtl/fp_align_add.sv
// Combinational datapath for the ALIGN and ADD stages.
// Ports:
//   x_i, y_i   : the two operands {sgn, exp, mant}.
//   a_sgn_o    : sign of the larger-magnitude operand A.
//   a_exp_o    : exponent of A.
//   a_mant_o   : {1, mant} of A.
//   b_mant_o   : {1, mant} of the smaller operand B, shifted right by
//                the exponent difference (truncating).
//   sub_o      : the signs differ, so the stage performs a subtraction.
//   drop_o     : B lies entirely below A's precision.
//   add_a_i, add_b_i, add_sub_i : registered operands for the ADD stage.
//   sum_o      : add/subtract result; the MSB is the carry-out.
module fp_align_add #(
  parameter int unsigned ExpWidth  = 8,
  parameter int unsigned MantWidth = 7,
  localparam int unsigned FPWidth  = 1 + ExpWidth + MantWidth
) (
  input  logic [FPWidth-1:0]   x_i,
  input  logic [FPWidth-1:0]   y_i,
  output logic                 a_sgn_o,
  output logic [ExpWidth-1:0]  a_exp_o,
  output logic [MantWidth:0]   a_mant_o,
  output logic [MantWidth:0]   b_mant_o,
  output logic                 sub_o,
  output logic                 drop_o,
  input  logic [MantWidth:0]   add_a_i,
  input  logic [MantWidth:0]   add_b_i,
  input  logic                 add_sub_i,
  output logic [MantWidth+1:0] sum_o
);

  logic               x_ge_y;
  logic [FPWidth-1:0] a, b;
  logic [ExpWidth-1:0] d;

  // Comparing {exp, mant} as one unsigned number orders by exponent
  // first and mantissa second.
  assign x_ge_y = x_i[FPWidth-2:0] >= y_i[FPWidth-2:0];
  assign a      = x_ge_y ? x_i : y_i;
  assign b      = x_ge_y ? y_i : x_i;
  assign d      = a[FPWidth-2 -: ExpWidth] - b[FPWidth-2 -: ExpWidth];

  assign a_sgn_o  = a[FPWidth-1];
  assign a_exp_o  = a[FPWidth-2 -: ExpWidth];
  assign a_mant_o = {1'b1, a[MantWidth-1:0]};
  assign b_mant_o = {1'b1, b[MantWidth-1:0]} >> d;
  assign sub_o    = a[FPWidth-1] ^ b[FPWidth-1];
  assign drop_o   = 32'(d) > 32'(MantWidth);

  assign sum_o = add_sub_i ? ({1'b0, add_a_i} - {1'b0, add_b_i})
                           : ({1'b0, add_a_i} + {1'b0, add_b_i});

endmodule

// File: rtl/fp_seq_accumulator.sv
// Multi-cycle floating-point accumulator. It sums count_i streamed
// operands, one per handshake, and presents the sum through a
// valid/ready port. The normaliser shifts left one bit per cycle, so
// the latency grows with the amount of cancellation.
// Ports:
//   clk_i, rst_i : clock and synchronous active-high reset.
//   start_i      : begin an accumulation (sampled only in IDLE).
//   count_i      : number of operands, sampled together with start_i.
//   busy_o       : high whenever the FSM is not in IDLE.
//   in_valid_i, in_ready_o, in_data_i   : operand stream.
//   out_valid_o, out_ready_i, out_data_o: result, held until taken.
//   out_nan_o, out_inf_o : result classification flags.
module fp_seq_accumulator
  import fp_seq_accumulator_pkg::*;
#(
  parameter int unsigned ExpWidth   = DefExpWidth,
  parameter int unsigned MantWidth  = DefMantWidth,
  parameter int unsigned CountWidth = 8,
  parameter int unsigned FPWidth    = 1 + ExpWidth + MantWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [CountWidth-1:0] count_i,
  output logic                  busy_o,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [FPWidth-1:0]    in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [FPWidth-1:0]    out_data_o,
  output logic                  out_nan_o,
  output logic                  out_inf_o
);

  localparam int unsigned E = ExpWidth;
  localparam int unsigned M = MantWidth;
  localparam logic [E-1:0] ExpMax = '1;
  localparam logic [E-1:0] ExpOne = {{(E-1){1'b0}}, 1'b1};
  localparam logic [CountWidth-1:0] CntOne = {{(CountWidth-1){1'b0}}, 1'b1};

  acc_state_e state_q, state_d;
  logic [FPWidth-1:0]    acc_q, acc_d, op_q, op_d;
  logic [CountWidth-1:0] rem_q, rem_d;
  logic                  a_sgn_q, a_sgn_d, sub_q, sub_d;
  logic [E-1:0]          a_exp_q, a_exp_d;
  logic [M:0]            a_mant_q, a_mant_d, b_mant_q, b_mant_d;
  logic                  res_sgn_q, res_sgn_d, res_fin_q, res_fin_d;
  logic [E-1:0]          res_exp_q, res_exp_d;
  logic [M:0]            res_mant_q, res_mant_d;

  logic               end_op;
  logic [FPWidth-1:0] end_val;

  logic acc_sgn, op_sgn, acc_nan, acc_inf, acc_zero, op_nan, op_inf, op_zero;
  logic [E-1:0] acc_exp, op_exp, exp_inc, exp_dec;
  logic [M-1:0] acc_mant, op_mant;

  logic         al_sgn, al_sub, al_drop;
  logic [E-1:0] al_exp;
  logic [M:0]   al_amant, al_bmant;
  logic [M+1:0] add_sum;

  assign acc_sgn  = acc_q[FPWidth-1];
  assign acc_exp  = acc_q[FPWidth-2 -: E];
  assign acc_mant = acc_q[M-1:0];
  assign op_sgn   = op_q[FPWidth-1];
  assign op_exp   = op_q[FPWidth-2 -: E];
  assign op_mant  = op_q[M-1:0];

  assign acc_nan  = is_nan(acc_sgn, acc_exp == '0, acc_exp == ExpMax, acc_mant == '0);
  assign acc_inf  = is_inf(acc_exp == ExpMax, acc_mant == '0);
  assign acc_zero = is_zero(acc_sgn, acc_exp == '0, acc_mant == '0);
  assign op_nan   = is_nan(op_sgn, op_exp == '0, op_exp == ExpMax, op_mant == '0);
  assign op_inf   = is_inf(op_exp == ExpMax, op_mant == '0);
  assign op_zero  = is_zero(op_sgn, op_exp == '0, op_mant == '0);

  assign exp_inc = a_exp_q + ExpOne;
  assign exp_dec = res_exp_q - ExpOne;

  fp_align_add #(
    .ExpWidth (ExpWidth),
    .MantWidth(MantWidth)
  ) u_align_add (
    .x_i      (acc_q),
    .y_i      (op_q),
    .a_sgn_o  (al_sgn),
    .a_exp_o  (al_exp),
    .a_mant_o (al_amant),
    .b_mant_o (al_bmant),
    .sub_o    (al_sub),
    .drop_o   (al_drop),
    .add_a_i  (a_mant_q),
    .add_b_i  (b_mant_q),
    .add_sub_i(sub_q),
    .sum_o    (add_sum)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    op_d       = op_q;
    a_sgn_d    = a_sgn_q;
    a_exp_d    = a_exp_q;
    a_mant_d   = a_mant_q;
    b_mant_d   = b_mant_q;
    sub_d      = sub_q;
    res_sgn_d  = res_sgn_q;
    res_exp_d  = res_exp_q;
    res_mant_d = res_mant_q;
    res_fin_d  = res_fin_q;
    end_op     = 1'b0;
    end_val    = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rem_d   = count_i;
          acc_d   = '0;
          state_d = (count_i == '0) ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (in_valid_i) begin
          op_d    = in_data_i;
          rem_d   = rem_q - CntOne;
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        // A NaN accumulator falls into the first branch, so it stays sticky.
        if (acc_nan || op_nan || (acc_inf && op_inf && (acc_sgn != op_sgn))) begin
          end_op  = 1'b1;
          end_val = '1;
        end else if (acc_inf) begin
          end_op  = 1'b1;
          end_val = acc_q;
        end else if (op_inf || acc_zero) begin
          end_op  = 1'b1;
          end_val = op_q;
        end else if (op_zero) begin
          end_op  = 1'b1;
          end_val = acc_q;
        end else if (al_drop) begin
          end_op  = 1'b1;
          end_val = {al_sgn, al_exp, al_amant[M-1:0]};
        end else begin
          a_sgn_d  = al_sgn;
          a_exp_d  = al_exp;
          a_mant_d = al_amant;
          b_mant_d = al_bmant;
          sub_d    = al_sub;
          state_d  = ST_ADD;
        end
      end
      ST_ADD: begin
        res_sgn_d = a_sgn_q;
        res_exp_d = a_exp_q;
        res_mant_d = add_sum[M:0];
        res_fin_d = 1'b0;
        state_d   = ST_NORM;
        if (!sub_q && add_sum[M+1]) begin
          if (exp_inc == ExpMax) begin
            res_exp_d  = ExpMax;
            res_mant_d = '0;
            res_fin_d  = 1'b1;
          end else begin
            res_exp_d  = exp_inc;
            res_mant_d = add_sum[M+1:1];
          end
        end else if (sub_q && (add_sum == '0)) begin
          res_sgn_d  = 1'b0;
          res_exp_d  = '0;
          res_mant_d = '0;
          res_fin_d  = 1'b1;
        end
      end
      ST_NORM: begin
        // res_fin marks Zero/inf results that must bypass the shifter.
        if (res_fin_q || res_mant_q[M]) begin
          end_op  = 1'b1;
          end_val = {res_sgn_q, res_exp_q, res_mant_q[M-1:0]};
        end else if (exp_dec == '0) begin
          end_op  = 1'b1;
          end_val = '0;
        end else begin
          res_mant_d = {res_mant_q[M-1:0], 1'b0};
          res_exp_d  = exp_dec;
        end
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (end_op) begin
      acc_d   = end_val;
      state_d = (rem_q == '0) ? ST_DONE : ST_ACCEPT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      rem_q      <= '0;
      op_q       <= '0;
      a_sgn_q    <= 1'b0;
      a_exp_q    <= '0;
      a_mant_q   <= '0;
      b_mant_q   <= '0;
      sub_q      <= 1'b0;
      res_sgn_q  <= 1'b0;
      res_exp_q  <= '0;
      res_mant_q <= '0;
      res_fin_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      op_q       <= op_d;
      a_sgn_q    <= a_sgn_d;
      a_exp_q    <= a_exp_d;
      a_mant_q   <= a_mant_d;
      b_mant_q   <= b_mant_d;
      sub_q      <= sub_d;
      res_sgn_q  <= res_sgn_d;
      res_exp_q  <= res_exp_d;
      res_mant_q <= res_mant_d;
      res_fin_q  <= res_fin_d;
    end
  end

  assign busy_o      = state_q != ST_IDLE;
  assign in_ready_o  = state_q == ST_ACCEPT;
  assign out_valid_o = state_q == ST_DONE;
  assign out_data_o  = (state_q == ST_DONE) ? acc_q : '0;
  assign out_nan_o   = (state_q == ST_DONE) && acc_nan;
  assign out_inf_o   = (state_q == ST_DONE) && acc_inf;

endmodule

// File: tb/tb_fp_seq_accumulator.sv
module tb_fp_seq_accumulator;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  count_i;
  logic        busy_o;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_data_o;
  logic        out_nan_o;
  logic        out_inf_o;

  int checks = 0;
  int errors = 0;
  logic [17:0] sb_q[$];  // {nan, inf, data}

  fp_seq_accumulator #(
    .ExpWidth  (8),
    .MantWidth (7),
    .CountWidth(8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .count_i    (count_i),
    .busy_o     (busy_o),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_nan_o  (out_nan_o),
    .out_inf_o  (out_inf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compares every accepted result against the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h required=none", out_data_o);
      end else begin
        logic [17:0] e;
        e = sb_q.pop_front();
        chk("out_data", 32'(out_data_o), 32'(e[15:0]));
        chk("out_inf", 32'(out_inf_o), 32'(e[16]));
        chk("out_nan", 32'(out_nan_o), 32'(e[17]));
      end
    end
  end

  // All tasks are entered 1 time unit after a rising edge.
  task automatic start_acc(input logic [7:0] cnt, input logic [15:0] data,
                           input logic nan, input logic inf, input logic push);
    if (push) sb_q.push_back({nan, inf, data});
    start_i = 1'b1;
    count_i = cnt;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic send_op(input logic [15:0] data);
    int n = 0;
    in_valid_i = 1'b1;
    in_data_i  = data;
    while (!in_ready_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("handshake", 32'(in_ready_o), 32'd1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid_o && cyc < 200) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    chk("valid_seen", 32'(out_valid_o), 32'd1);
  endtask

  task automatic take_result();
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    chk("valid_drop", 32'(out_valid_o), 32'd0);
    chk("idle_after", 32'(busy_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_i = 1'b1; start_i = 1'b0; count_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_outputs", {26'd0, busy_o, in_ready_o, out_valid_o, out_nan_o, out_inf_o,
                        |out_data_o}, 32'd0);
    rst_i = 1'b0;

    // 1.0 + 2.0 = 3.0, result held while not ready; start pulses while busy ignored.
    start_acc(8'd2, 16'h4040, 1'b0, 1'b0, 1'b1);
    send_op(16'h3F80);
    start_i = 1'b1; count_i = 8'd0;
    repeat (2) begin @(posedge clk_i); #1; end
    start_i = 1'b0;
    chk("start_ignored", 32'(in_ready_o), 32'd1);
    send_op(16'h4000);
    wait_valid(cyc);
    chk("lat_no_shift", 32'(cyc), 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk("hold_valid", 32'(out_valid_o), 32'd1);
      chk("hold_data", 32'(out_data_o), 32'h4040);
    end
    take_result();

    // 1.0 - 0.9921875: heavy cancellation, NORM lasts 8 cycles.
    start_acc(8'd2, 16'h3C00, 1'b0, 1'b0, 1'b1);
    send_op(16'h3F80);
    send_op(16'hBF7E);
    wait_valid(cyc);
    chk("lat_norm8", 32'(cyc), 32'd10);
    take_result();

    // +inf + -inf -> NaN; later operand still accepted, NaN sticks.
    start_acc(8'd3, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    send_op(16'h7F80);
    send_op(16'hFF80);
    send_op(16'h3F80);
    wait_valid(cyc);
    take_result();

    // 256 + 1.0: d=8 exceeds mantissa width, small operand dropped.
    start_acc(8'd2, 16'h4380, 1'b0, 1'b0, 1'b1);
    send_op(16'h3F80);
    send_op(16'h4380);
    wait_valid(cyc);
    chk("lat_drop", 32'(cyc), 32'd1);
    take_result();

    // 1.0 + -1.0 -> positive Zero.
    start_acc(8'd2, 16'h0000, 1'b0, 1'b0, 1'b1);
    send_op(16'h3F80);
    send_op(16'hBF80);
    wait_valid(cyc);
    take_result();

    // Single +inf operand -> inf flag.
    start_acc(8'd1, 16'h7F80, 1'b0, 1'b1, 1'b1);
    send_op(16'h7F80);
    wait_valid(cyc);
    take_result();

    // count=0: valid immediately after start; start while in DONE ignored.
    start_acc(8'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("cnt0_valid", 32'(out_valid_o), 32'd1);
    start_i = 1'b1; count_i = 8'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("cnt0_still_done", 32'(out_valid_o), 32'd1);
    take_result();

    // Reset in the middle of NORM, then a fresh run.
    start_acc(8'd2, 16'h0000, 1'b0, 1'b0, 1'b0);
    send_op(16'h3F80);
    send_op(16'hBF7E);
    repeat (3) begin @(posedge clk_i); #1; end
    chk("in_norm_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("midrst_outputs", {26'd0, busy_o, in_ready_o, out_valid_o, out_nan_o, out_inf_o,
                           |out_data_o}, 32'd0);
    start_acc(8'd1, 16'h4040, 1'b0, 1'b0, 1'b1);
    send_op(16'h4040);
    wait_valid(cyc);
    take_result();

    repeat (5) @(posedge clk_i);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_seq_accumulator.md
Name: fp_seq_accumulator

Overview:
Parametrised, multi-cycle floating-point accumulator that serves the CmdOpAccumulate command.
- Sums a host-specified number of streamed operands in a configurable ExpWidth/MantWidth format, one operand at a time, and presents the result through a valid/ready output.
- Normalisation runs as a sequential shifter, so latency varies with the amount of cancellation.
- Sits between the command decoder and the result serialiser.

Parameters:
ExpWidth, 8, exponent field width (bias 2^(ExpWidth-1)-1)
MantWidth, 7, stored mantissa width (hidden 1 implied)
CountWidth, 8, width of operand-count field
FPWidth, 1+ExpWidth+MantWidth, derived operand width; do not override

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
start_i  input  1  begin new accumulation; sampled only in IDLE
count_i  input  CountWidth  number of operands to sum; sampled with start_i
busy_o  output  1  high in every state except IDLE
in_valid_i  input  1  operand valid
in_ready_o  output  1  operand accepted when in_valid_i && in_ready_o
in_data_i  input  FPWidth  operand {sgn, exp, mant}
out_valid_o  output  1  result valid; held until taken
out_ready_i  input  1  consumer ready
out_data_o  output  FPWidth  accumulated result
out_nan_o  output  1  out_data_o is NaN (valid with out_valid_o)
out_inf_o  output  1  out_data_o is +/-inf (valid with out_valid_o)

Behaviour:
- Reset (rst_i high on a clock edge) forces IDLE from any state, including mid-operation. On reset: busy_o=0, in_ready_o=0, out_valid_o=0, out_data_o=0, out_nan_o=0, out_inf_o=0, accumulator=Zero, remaining count=0.
- Format rules:
  - Zero is all-zero. Any other exp==0 pattern (including -0) is NaN.
  - exp all-ones with mant==0 is +/-inf. exp all-ones with mant!=0 is NaN.
  - There are no denormals. Standard NaN is all-ones.
- FSM states: IDLE, ACCEPT, ALIGN, ADD, NORM, DONE.
- IDLE:
  - start_i=1 loads remaining=count_i and acc=Zero.
  - Next state is DONE if count_i==0, else ACCEPT.
  - start_i is ignored in every other state.
- ACCEPT: in_ready_o=1. On handshake, latch the operand, decrement remaining, go to ALIGN.
- ALIGN (1 cycle):
  - Special cases resolve here and jump straight to the end-of-operand check, skipping ADD/NORM:
    - Any NaN operand, or inf+opposite inf, gives Standard NaN.
    - inf+x gives that inf.
    - x+Zero gives x.
  - Otherwise order the two values by magnitude (exp, then mant) so A>=B, with d=expA-expB.
  - d>MantWidth: result=A (B is dropped entirely).
- ADD (1 cycle):
  - Operands are {1,mant}, with B shifted right by d. Shifted-out bits are truncated (round toward zero).
  - Same signs: sum. On carry-out, shift right 1 and exp+1; if exp reaches all-ones, result is signed inf.
  - Different signs: A-B. A zero difference gives Zero (positive).
  - Result sign is the sign of A.
- NORM:
  - 1 cycle if the leading bit is set. Otherwise shift left 1 and exp-1 per cycle until the leading bit is set.
  - exp reaching 0 flushes the result to Zero and ends NORM.
- End-of-operand check: write result to acc. Go to DONE if remaining==0, else ACCEPT.
- Once acc is NaN, it stays Standard NaN: later operands are still accepted but not summed.
- DONE:
  - out_valid_o=1, out_data_o=acc, and flags decoded from acc.
  - Outputs are stable while out_ready_i=0.
  - On out_valid_o && out_ready_i, go to IDLE; out_valid_o drops the next cycle.
- Operand latency is handshake + ALIGN + ADD + NORM(1+k) cycles. A special case takes handshake + ALIGN.
- in_ready_o is low in all states except ACCEPT; there is no back-to-back operand acceptance.

Decomposition:
- Shared package gets:
  - default ExpWidth/MantWidth (8/7);
  - the FSM state enum (acc_state_e);
  - CmdOpAccumulate.
- Classification is a width-parametrised is_nan/is_inf/is_zero function set in the same package, taking ExpWidth/MantWidth via a parametrised class or explicit field arguments.
- One natural sub-module: fp_align_add, the combinational ordering, alignment shift and add/subtract with carry-out, used in ALIGN/ADD. The NORM shifter stays in the top-level FSM.

Test Plan:
- count=2: 0x3F80 (1.0), 0x4000 (2.0) -> out 0x4040 (3.0), nan=0, inf=0, held 3 cycles with out_ready_i=0.
- count=2: 0x3F80, 0xBF7E (-0.9921875) -> out 0x3C00; NORM for the second operand lasts exactly 8 cycles.
- count=3: 0x7F80 (+inf), 0xFF80 (-inf), 0x3F80 -> out 0xFFFF, nan=1; all three operands handshaked.
- count=2: 0x4380 (256.0), 0x3F80 -> out 0x4380 (d=8, truncated); count=2: 0x3F80, 0xBF80 -> 0x0000.
- count=0 with start_i -> out 0x0000 valid the cycle after start; start_i pulses while busy are ignored.
- rst_i asserted during NORM -> next cycle all outputs 0 and IDLE; new start with count=1 and 0x4040 -> out 0x4040.
